// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester agent: FSM encoding,
// default timing parameters and the statistics counter width.
package arb_pkg;

  // Agent FSM: waiting for a command, holding req, enforcing the idle gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAPW = 2'd2
  } arb_state_e;

  // Default idle cycles between bursts and default wait-counter width.
  localparam int ARB_GAP_DEF  = 1;
  localparam int ARB_TO_W_DEF = 4;

  // Width of the gap down-counter (GAP range is 0..15).
  localparam int ARB_GAP_W    = 4;

  // Width of the wait_cycles statistics counter.
  localparam int ARB_STATS_W  = 16;

endpackage

// File: rtl/arb_requester_sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones once
// reached; clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for a req/gnt arbiter. Accepts a burst command, holds
// req until cmd_len+1 beats have been granted (or the grant-wait timeout
// fires), then keeps req low for GAP cycles before taking the next command.
// Optional wait statistics are built when ARB_REQ_STATS_EN is defined;
// otherwise wait_cycles is tied to zero.
// TO_W must be at least 2.
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int GAP   = ARB_GAP_DEF,
  parameter int TO_W  = ARB_TO_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   req,
  input  logic                   gnt,
  output logic                   beat,
  output logic                   beat_last,
  output logic                   busy,
  output logic                   to_err,
  output logic [ARB_STATS_W-1:0] wait_cycles
);

  // Gap counter is loaded with GAP-1 on entering GAPW and counts down to 0.
  localparam logic [ARB_GAP_W-1:0] GAP_LOAD = ARB_GAP_W'((GAP > 0) ? GAP - 1 : 0);
  // An ungranted edge seen with the counter at this value is the
  // (2^TO_W-1)-th consecutive one, so the burst aborts on that edge.
  localparam logic [TO_W-1:0] WAIT_ABORT = {{(TO_W-1){1'b1}}, 1'b0};

  arb_state_e           state_q, state_d;
  logic [LEN_W-1:0]     remain_q, remain_d;
  logic [ARB_GAP_W-1:0] gap_q, gap_d;
  logic                 req_q, req_d;
  logic                 to_err_q, to_err_d;
  logic [TO_W-1:0]      wait_cnt;
  logic                 wait_inc;
  logic                 wait_clr;
  logic                 leave_req;

  // Next-state logic: command acceptance, beat counting, timeout, gap.
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    gap_d     = gap_q;
    to_err_d  = 1'b0;
    wait_inc  = 1'b0;
    wait_clr  = 1'b1;
    leave_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          remain_d = cmd_len;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          if (remain_q == '0) begin
            leave_req = 1'b1;
          end else begin
            remain_d = remain_q - 1'b1;
          end
        end else if (wait_cnt == WAIT_ABORT) begin
          // Starved too long: drop the rest of the burst and flag it.
          to_err_d  = 1'b1;
          remain_d  = '0;
          leave_req = 1'b1;
        end else begin
          wait_inc = 1'b1;
          wait_clr = 1'b0;
        end
      end
      ST_GAPW: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (leave_req) begin
      if (GAP > 0) begin
        state_d = ST_GAPW;
        gap_d   = GAP_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end
    req_d = (state_d == ST_REQ);
  end

  // State, burst and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      gap_q    <= '0;
      req_q    <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      gap_q    <= gap_d;
      req_q    <= req_d;
      to_err_q <= to_err_d;
    end
  end

  // Consecutive ungranted cycles while requesting.
  sat_counter #(.W(TO_W)) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .count   (wait_cnt)
  );

`ifdef ARB_REQ_STATS_EN
  // Lifetime count of requesting-but-not-granted cycles.
  sat_counter #(.W(ARB_STATS_W)) u_stats (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (req_q & ~gnt),
    .count   (wait_cycles)
  );
`else
  assign wait_cycles = '0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign req       = req_q;
  assign to_err    = to_err_q;
  assign beat      = req_q & gnt;
  assign beat_last = beat & (remain_q == '0);

endmodule

// File: doc/arb_requester.md
# arb_requester

Client-side agent for the two-input round-priority arbiter: it accepts burst commands from a local master and drives one `req`/`gnt` pair. The agent raises `req`, counts granted beats, drops `req` when the burst completes, and enforces an idle gap before the next burst. A grant-wait timeout keeps a starved client from stalling its master.

## Interface
- `LEN_W`, 4: width of `cmd_len`; a burst is `cmd_len+1` beats (1..2^LEN_W).
- `GAP`, 1: idle cycles with `req` low after a burst completes or aborts (0..15).
- `TO_W`, 4: width of the wait counter; timeout fires after 2^TO_W−1 consecutive non-granted cycles.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_len` in LEN_W: beats minus one; sampled on acceptance.
- `req` out 1: request to the arbiter; registered.
- `gnt` in 1: grant from the arbiter; may already be high when `req` rises (sticky grant).
- `beat` out 1: combinational, `req & gnt`; one beat transfers per edge while high.
- `beat_last` out 1: `beat` on the final beat of the burst.
- `busy` out 1: state ≠ IDLE.
- `to_err` out 1: one-cycle registered pulse on timeout abort.
- `wait_cycles` out 16: statistics counter (see Configuration).

## Operation
- FSM states: IDLE, REQ, GAPW.
- IDLE: `cmd_ready`=1. On acceptance, load `remain`=`cmd_len` and go to REQ.
- REQ: `req`=1, `cmd_ready`=0.
  - Each edge with `gnt`=1: if `remain`=0, go to GAPW (or to IDLE if GAP=0); otherwise decrement `remain`. The wait counter clears.
  - Each edge with `gnt`=0: increment the wait counter. `req` stays high when the grant is lost mid-burst; beats resume when `gnt` returns.
  - When the wait counter reaches 2^TO_W−1: abort. Pulse `to_err` next cycle, go to GAPW (or IDLE if GAP=0), and discard the remaining beats.
- GAPW: `req`=0, `cmd_ready`=0. Count GAP cycles, then go to IDLE.
- `beat_last` = `beat & (remain==0)`.
- `gnt` arriving with `req` low is ignored; no beat is produced.
- Reset values: state IDLE, `req`=0, `busy`=0, `to_err`=0, `remain`=0, wait counter=0, `wait_cycles`=0. `cmd_ready` is combinational from IDLE and reads 1, but no command is accepted while `reset_n` is low.
- Asserting reset mid-burst drops `req` immediately (asynchronously). The burst is lost and no `to_err` is produced.

## Timing
- Command accepted at edge k: `req` is high from k+1. With `gnt` already high, the first beat occurs at edge k+1.
- Burst of N beats with continuous grant: `req` is high for exactly N cycles. It falls after the edge of the last beat.
- Next acceptance is earliest at edge (last beat)+GAP+1. `cmd_ready` is high in the cycle before that edge.
- Timeout: with `gnt` low from `req` rise, the abort edge is k+2^TO_W−1. `req` and `to_err` change after that edge.
- No combinational path from `cmd_valid` to `req`. The only combinational path from `gnt` is to `beat` and `beat_last`.

## Configuration
- `ARB_REQ_STATS_EN` defined: `wait_cycles` counts every cycle with `req`=1 and `gnt`=0. It saturates at 0xFFFF and clears only on reset.
- Not defined: no counter logic; `wait_cycles` is tied to 0.

## Structure
- Shared package `arb_pkg`:
  - FSM state encoding (IDLE/REQ/GAPW).
  - Default GAP and TO_W constants.
  - Stats counter width (16).
- One sub-module is natural: `sat_counter`, a parameterised saturating up-counter with clear. It implements `wait_cycles` and may be reused for the wait counter.

## Test plan
- Reset, then `cmd_len`=3, `gnt` held 1: `req` high 4 cycles, 4 `beat`s, `beat_last` on the 4th. `cmd_ready` returns 1 after GAP=1 cycle.
- `cmd_len`=2, `gnt` pattern 1,0,0,1,1: `req` high 5 cycles, 3 beats, no `to_err`; with `ARB_REQ_STATS_EN`, `wait_cycles`=2.
- `gnt` held 0, TO_W=4: `to_err` pulses once, 15 cycles after `req` rises, then `req`=0 and zero beats counted.
- Two agents on one arbiter (arbiter reset driven by `!reset_n`), both requesting `cmd_len`=1:
  - Grants never overlap.
  - Each agent completes 2 beats.
  - `gnt` seen while that agent's `req`=0 produces no `beat`.
- Assert `reset_n` low mid-burst (after 1 of 4 beats): `req`, `busy`, `to_err` drop to 0 asynchronously. After release, `cmd_ready`=1 and a new `cmd_len`=0 completes in 1 beat.
